dest_dispatcher: RTL and testbench
==================================

DEST_DISPATCHER -- requirements
Module: dest_dispatcher

Interface
REQ-001 The block SHALL have parameter LINE_SIZE, default 12, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port valid_in, input, 1 bit: data_in holds a word offered by the upstream referee stage.
REQ-005 The block SHALL have port data_in, input, LINE_SIZE bits: the offered word; bits [LINE_SIZE-1:LINE_SIZE-2] are the destination index 0-3.
REQ-006 The block SHALL have port ready_out, output, 1 bit: registered; the block can accept a word this cycle.
REQ-007 The block SHALL have port almost_full_signal, input, 4 bits: per-destination FIFO almost-full flags.
REQ-008 The block SHALL have port push_signal, output, 4 bits: registered one-hot push strobe to the destination FIFOs.
REQ-009 The block SHALL have port data_out, output, LINE_SIZE bits: registered word presented to the destination FIFOs.
REQ-010 The block SHALL have port idle_out, output, 1 bit: registered; high when the buffer is empty and push_signal is 0.
REQ-011 The block SHALL have port error_out, output, 1 bit: sticky stall-watchdog flag (REQ-026).

Function
REQ-012 The block SHALL accept a word on a rising edge where valid_in=1 and ready_out=1; it SHALL ignore valid_in when ready_out=0.
REQ-013 Accepted words SHALL enter a 2-entry in-order skid buffer; the occupancy count is 0-2.
REQ-014 ready_out SHALL be registered as 1 when next occupancy is below 2, else 0.
REQ-015 Dispatch condition: occupancy>0 and almost_full_signal[dest(head)]=0, sampled in the same cycle.
REQ-016 On dispatch the next edge SHALL set push_signal to one-hot of dest(head), load data_out with head, and pop head.
REQ-017 Without dispatch the next edge SHALL set push_signal to 4'b0000; data_out SHALL hold its last value.
REQ-018 Latency SHALL be one cycle: a word accepted at edge N into an empty buffer with its destination not almost-full appears on push_signal/data_out after edge N+1.
REQ-019 Sustained throughput SHALL be one word per cycle when no destination is almost-full.
REQ-020 Simultaneous accept and dispatch SHALL leave occupancy unchanged; word order SHALL be preserved.
REQ-021 A blocked head SHALL block all later words (no reordering), even if their destinations are free.
REQ-022 FSM states SHALL be IDLE (occupancy 0), ACTIVE (dispatching), BLOCKED (occupancy>0, head destination almost-full).
REQ-023 Transitions: IDLE->ACTIVE on accept; ACTIVE->BLOCKED when head destination almost-full; BLOCKED->ACTIVE when it clears; ACTIVE->IDLE when the last word dispatches with no accept.
REQ-024 almost_full_signal changing on the dispatch cycle SHALL use only the value sampled that cycle.

Reset
REQ-025 When reset=1 at an edge, the block SHALL clear the buffer, occupancy=0, FSM=IDLE, push_signal=0, data_out=0, ready_out=1, idle_out=1, error_out=0; reset mid-stall SHALL discard buffered words without pushing them.

Configuration
REQ-026 With macro STALL_WDOG_EN defined, a 5-bit counter SHALL count consecutive BLOCKED cycles, clear on leaving BLOCKED, and set error_out sticky when it reaches 16; only reset SHALL clear error_out.
REQ-027 Without STALL_WDOG_EN, no watchdog logic SHALL be built and error_out SHALL be constant 0.

Verification
REQ-028 After reset: all outputs at reset values (ready_out=1, idle_out=1, push_signal=0, data_out=0).
REQ-029 Single word 12'h8A5 (dest 2), almost_full=0 -> next cycle push_signal=4'b0100, data_out=12'h8A5, then push=0, idle_out=1.
REQ-030 Back-to-back 12'h001,12'h402,12'hC03 with almost_full=0 -> pushes 0001,0010,1000 on three consecutive cycles, in order.
REQ-031 almost_full=4'b0010, send 12'h455 then 12'h066 -> no push, ready_out=0 after two words; clear flag -> 0010 then 0001 on consecutive cycles.
REQ-032 With STALL_WDOG_EN, hold destination 1 almost-full for 16 cycles -> error_out=1, stays 1 after clearing, cleared by reset.
REQ-033 Reset asserted while two words buffered -> no push follows, occupancy 0, ready_out=1.

Source files
------------

// File: rtl/dest_dispatcher_if.sv
// Bundle between the upstream referee stage and the destination FIFOs.
// fsm_state exposes the dispatcher FSM for observation.
interface dest_dispatcher_if #(
  parameter int LINE_SIZE = 12
);
  logic                 valid_in;
  logic [LINE_SIZE-1:0] data_in;
  logic                 ready_out;
  logic [3:0]           almost_full_signal;
  logic [3:0]           push_signal;
  logic [LINE_SIZE-1:0] data_out;
  logic                 idle_out;
  logic                 error_out;
  logic [1:0]           fsm_state;

  modport master (
    output valid_in, data_in, almost_full_signal,
    input  ready_out, push_signal, data_out, idle_out, error_out, fsm_state
  );

  modport slave (
    input  valid_in, data_in, almost_full_signal,
    output ready_out, push_signal, data_out, idle_out, error_out, fsm_state
  );
endinterface

// File: rtl/dest_dispatcher.sv
// Routes words through a 2-entry in-order skid buffer to one of four destination FIFOs.
// Optional stall watchdog enabled by defining STALL_WDOG_EN.
module dest_dispatcher #(
  parameter int LINE_SIZE = 12
) (
  input  logic               clk,
  input  logic               reset,
  dest_dispatcher_if.slave   bus
);
  // Handshake: a word transfers on a rising edge where valid_in and ready_out are both 1;
  // ready_out is registered, so valid_in is ignored whenever ready_out is 0.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [LINE_SIZE-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
  logic [1:0]           cnt_q, cnt_d, cnt_pop;
  logic [3:0]           push_q, push_d;
  logic [LINE_SIZE-1:0] dout_q, dout_d;
  logic                 ready_q, ready_d;
  logic                 idle_q, idle_d;
  logic [1:0]           head_dest;
  logic                 accept, dispatch, head_blocked;

  always_comb begin
    head_dest    = buf0_q[LINE_SIZE-1 -: 2];
    accept       = bus.valid_in && ready_q;
    head_blocked = (cnt_q != 2'd0) && bus.almost_full_signal[head_dest];
    dispatch     = (cnt_q != 2'd0) && !bus.almost_full_signal[head_dest];

    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    cnt_pop = cnt_q;
    push_d  = 4'b0000;
    dout_d  = dout_q;

    if (dispatch) begin
      push_d  = 4'b0001 << head_dest;
      dout_d  = buf0_q;
      buf0_d  = buf1_q;
      cnt_pop = cnt_q - 2'd1;
    end

    // New word lands behind whatever survives the pop, keeping arrival order.
    cnt_d = cnt_pop;
    if (accept) begin
      if (cnt_pop == 2'd0) buf0_d = bus.data_in;
      else                 buf1_d = bus.data_in;
      cnt_d = cnt_pop + 2'd1;
    end

    ready_d = (cnt_d < 2'd2);
    idle_d  = (cnt_d == 2'd0) && (push_d == 4'b0000);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE: begin
        if (head_blocked)        state_d = BLOCKED;
        else if (cnt_d == 2'd0)  state_d = IDLE;
      end
      BLOCKED: if (!head_blocked) state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= 2'd0;
      push_q  <= 4'b0000;
      dout_q  <= '0;
      ready_q <= 1'b1;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      cnt_q   <= cnt_d;
      push_q  <= push_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.ready_out   = ready_q;
  assign bus.push_signal = push_q;
  assign bus.data_out    = dout_q;
  assign bus.idle_out    = idle_q;
  assign bus.fsm_state   = state_q;

`ifdef STALL_WDOG_EN
  logic [4:0] wdog_q;
  logic       error_q;

  // Counter saturates at 16; error latches once reached and only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q  <= 5'd0;
      error_q <= 1'b0;
    end else begin
      if (state_q == BLOCKED) begin
        if (wdog_q != 5'd16) wdog_q <= wdog_q + 5'd1;
      end else begin
        wdog_q <= 5'd0;
      end
      if (wdog_q == 5'd16) error_q <= 1'b1;
    end
  end

  assign bus.error_out = error_q;
`else
  assign bus.error_out = 1'b0;
`endif
endmodule

// File: tb/tb_dest_dispatcher.sv
// Bench for dest_dispatcher: per-cycle vector table plus a push scoreboard and corner sequences.
module tb_dest_dispatcher;
  localparam int W = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_dispatcher_if #(.LINE_SIZE(W)) bus ();
  dest_dispatcher #(.LINE_SIZE(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int passed = 0;
  logic [W+3:0] exp_q[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [3:0]   af;
    logic         acc;
    logic [3:0]   p;
    logic [W-1:0] q;
    logic         r;
    logic         i;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [3:0] onehot(input logic [W-1:0] d);
    logic [1:0] k;
    k = d[W-1:W-2];
    return 4'b0001 << k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every nonzero push must match the oldest expected word.
  task automatic monitor();
    logic [W+3:0] e;
    if (bus.push_signal != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected_push: got push %0h data %0h expected no push",
                 bus.push_signal, bus.data_out);
      end else begin
        e = exp_q.pop_front();
        check("sb_push", 32'(bus.push_signal), 32'(e[W+3:W]));
        check("sb_data", 32'(bus.data_out), 32'(e[W-1:0]));
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic [3:0] af, input logic acc);
    bus.valid_in           = v;
    bus.data_in            = d;
    bus.almost_full_signal = af;
    if (acc) exp_q.push_back({onehot(d), d});
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  initial begin
    reset = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.almost_full_signal = 4'b0000;

    tbl[0]  = '{1'b1, 12'h8A5, 4'h0, 1'b1, 4'h0, 12'h000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h4, 12'h8A5, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 12'h8A5, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 12'h001, 4'h0, 1'b1, 4'h0, 12'h8A5, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 12'h402, 4'h0, 1'b1, 4'h1, 12'h001, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 12'hC03, 4'h0, 1'b1, 4'h2, 12'h402, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h8, 12'hC03, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 12'hC03, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 12'h455, 4'h2, 1'b1, 4'h0, 12'hC03, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 12'h066, 4'h2, 1'b1, 4'h0, 12'hC03, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 12'h3FF, 4'h2, 1'b0, 4'h0, 12'hC03, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h2, 12'h455, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h1, 12'h066, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 12'h066, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 12'h455, 4'h0, 1'b1, 4'h0, 12'h066, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 12'h000, 4'h2, 1'b0, 4'h0, 12'h066, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h2, 12'h455, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 12'h455, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(bus.ready_out), 32'd1);
    check("rst_idle",  32'(bus.idle_out), 32'd1);
    check("rst_push",  32'(bus.push_signal), 32'd0);
    check("rst_data",  32'(bus.data_out), 32'd0);
    check("rst_error", 32'(bus.error_out), 32'd0);
    check("rst_state", 32'(bus.fsm_state), 32'd0);

    // Vector table
    for (int k = 0; k < 18; k++) begin
      cycle(tbl[k].v, tbl[k].d, tbl[k].af, tbl[k].acc);
      check($sformatf("tbl%0d_push", k),  32'(bus.push_signal), 32'(tbl[k].p));
      check($sformatf("tbl%0d_data", k),  32'(bus.data_out), 32'(tbl[k].q));
      check($sformatf("tbl%0d_ready", k), 32'(bus.ready_out), 32'(tbl[k].r));
      check($sformatf("tbl%0d_idle", k),  32'(bus.idle_out), 32'(tbl[k].i));
    end
    check("tbl_sb_empty", 32'(exp_q.size()), 32'd0);

    // Watchdog: head destination 1 held almost-full
    cycle(1'b1, 12'h455, 4'h2, 1'b1);
    repeat (5) cycle(1'b0, 12'h000, 4'h2, 1'b0);
    check("wd_state_blocked", 32'(bus.fsm_state), 32'd2);
    check("wd_error_early", 32'(bus.error_out), 32'd0);
    repeat (17) cycle(1'b0, 12'h000, 4'h2, 1'b0);
    check("wd_no_push", 32'(bus.push_signal), 32'd0);
`ifdef STALL_WDOG_EN
    check("wd_error_set", 32'(bus.error_out), 32'd1);
`else
    check("wd_error_off", 32'(bus.error_out), 32'd0);
`endif
    cycle(1'b0, 12'h000, 4'h0, 1'b0);
    check("wd_release_push", 32'(bus.push_signal), 32'h2);
    cycle(1'b0, 12'h000, 4'h0, 1'b0);
`ifdef STALL_WDOG_EN
    check("wd_error_sticky", 32'(bus.error_out), 32'd1);
`else
    check("wd_error_off2", 32'(bus.error_out), 32'd0);
`endif
    reset = 1'b1;
    cycle(1'b0, 12'h000, 4'h0, 1'b0);
    reset = 1'b0;
    check("wd_error_cleared", 32'(bus.error_out), 32'd0);

    // Reset while two words are buffered: they must vanish
    cycle(1'b1, 12'h455, 4'h2, 1'b1);
    cycle(1'b1, 12'h066, 4'h2, 1'b1);
    check("mid_ready_full", 32'(bus.ready_out), 32'd0);
    reset = 1'b1;
    exp_q.delete();
    cycle(1'b0, 12'h000, 4'h0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 12'h000, 4'h0, 1'b0);
      check($sformatf("mid_push%0d", k), 32'(bus.push_signal), 32'd0);
    end
    check("mid_ready", 32'(bus.ready_out), 32'd1);
    check("mid_idle",  32'(bus.idle_out), 32'd1);
    check("mid_data",  32'(bus.data_out), 32'd0);
    check("mid_state", 32'(bus.fsm_state), 32'd0);

    // Back-to-back words with every destination free: one push per cycle
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, W'($urandom_range(0, 4095)), 4'h0, 1'b1);
      if (k > 0) check($sformatf("b2b_push%0d", k), 32'(bus.push_signal != 4'b0000), 32'd1);
    end

    // Random traffic, no back-pressure
    for (int k = 0; k < 150; k++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      cycle(v, W'($urandom_range(0, 4095)), 4'h0, v);
      check("rnd_ready", 32'(bus.ready_out), 32'd1);
    end
    repeat (3) cycle(1'b0, 12'h000, 4'h0, 1'b0);
    check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
    check("rnd_idle", 32'(bus.idle_out), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
